// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle control sequencer placed directly upstream of the ALU. It steps
//   IF/ID/EX/MEM/WB for the latched instruction and drives the ALU function
//   code, operand selects and the datapath write enables. Memory accesses use
//   a ready handshake, so a slow memory simply holds the sequencer in IF/MEM.
//
//   Optional feature: define CTRL_INST_COUNT_EN to build the retired-
//   instruction counter. Without it num_inst is tied to zero and no counter
//   flops exist.
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   inst                  IR contents; opcode [15:12], func [5:0]
//   mem_ready             memory finished the current read/write this cycle
//   alu_b_result          ALU branch flag (gates the PC load in the datapath)
//   func_code             ALU function select
//   alu_src_a/alu_src_b   ALU operand selects
//   pc_source, pc_write, pc_write_cond   PC update controls
//   i_or_d, mem_read, mem_write          memory address select and requests
//   ir_write, reg_write, reg_dst, mem_to_reg, wwd   datapath enables/selects
//   is_halted             high after HLT until reset
//   num_inst              retired-instruction count (wraps)
//
// ALU function codes
//   ADD=0 SUB=1 AND=2 ORR=3 NOT=4 TCP=5 SHL=6 SHR=7 LHI=8 JMP=9
//   BNE=10 BEQ=11 BGZ=12 BLZ=13
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] inst,
  input  logic                 mem_ready,
  input  logic                 alu_b_result,
  output logic [3:0]           func_code,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_source,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           mem_to_reg,
  output logic                 wwd,
  output logic                 is_halted,
  output logic [CNT_WIDTH-1:0] num_inst
);

  localparam logic [2:0] ST_IF   = 3'd0;
  localparam logic [2:0] ST_ID   = 3'd1;
  localparam logic [2:0] ST_EX   = 3'd2;
  localparam logic [2:0] ST_MEM  = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd5;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam logic [3:0] FUNC_ORR = 4'd3;
  localparam logic [3:0] FUNC_LHI = 4'd8;
  localparam logic [3:0] FUNC_JMP = 4'd9;
  localparam logic [3:0] FUNC_BNE = 4'd10;
  localparam logic [3:0] FUNC_BEQ = 4'd11;
  localparam logic [3:0] FUNC_BGZ = 4'd12;
  localparam logic [3:0] FUNC_BLZ = 4'd13;

  logic [2:0] state, nextState;
  logic [3:0] opcode;
  logic [5:0] funct;
  logic       isRType, isRAlu, isJpr, isJrl, isWwd, isHlt, isLegal;
  logic       unusedInputs;

  // Register fields are consumed by the datapath, and the branch flag gates
  // the PC load there; the sequencer itself never needs them.
  assign unusedInputs = ^{alu_b_result, inst[11:6]};

  // Instruction class decode shared by next-state and output logic.
  always_comb begin
    opcode  = inst[15:12];
    funct   = inst[5:0];
    isRType = (opcode == OP_RTYPE);
    isRAlu  = isRType && (funct < 6'd8);
    isJpr   = isRType && (funct == FN_JPR);
    isJrl   = isRType && (funct == FN_JRL);
    isWwd   = isRType && (funct == FN_WWD);
    isHlt   = isRType && (funct == FN_HLT);
    isLegal = (opcode <= OP_JAL) || isRAlu || isJpr || isJrl || isWwd || isHlt;
  end

  // State register; reset parks the sequencer at the fetch state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IF;
    else          state <= nextState;
  end

  // Next-state sequencing. IF and MEM wait on the memory handshake; illegal
  // opcodes are dropped back to IF straight from ID.
  always_comb begin
    nextState = state;
    case (state)
      ST_IF:  if (mem_ready) nextState = ST_ID;
      ST_ID: begin
        if (isHlt)         nextState = ST_HALT;
        else if (!isLegal) nextState = ST_IF;
        else               nextState = ST_EX;
      end
      ST_EX: begin
        if (isRAlu || opcode == OP_ADI || opcode == OP_ORI || opcode == OP_LHI)
          nextState = ST_WB;
        else if (opcode == OP_LWD || opcode == OP_SWD)
          nextState = ST_MEM;
        else
          nextState = ST_IF;
      end
      ST_MEM: if (mem_ready) nextState = (opcode == OP_LWD) ? ST_WB : ST_IF;
      ST_WB:   nextState = ST_IF;
      ST_HALT: nextState = ST_HALT;
      default: nextState = ST_IF;
    endcase
  end

  // Control outputs decoded from state and instruction. Everything is forced
  // to its idle value while reset is asserted so an in-flight memory request
  // drops immediately rather than at the next clock.
  always_comb begin
    func_code     = FUNC_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    pc_source     = 2'd0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'd0;
    mem_to_reg    = 2'd0;
    wwd           = 1'b0;
    is_halted     = 1'b0;
    if (reset_n) begin
      case (state)
        ST_IF: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        ST_ID: alu_src_b = 2'd2;
        ST_EX: begin
          if (isRAlu) begin
            func_code = {1'b0, funct[2:0]};
            alu_src_a = 1'b1;
          end else begin
            case (opcode)
              OP_ADI, OP_LWD, OP_SWD: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
              end
              OP_ORI, OP_LHI: begin
                func_code = (opcode == OP_ORI) ? FUNC_ORR : FUNC_LHI;
                alu_src_a = 1'b1;
                alu_src_b = 2'd3;
              end
              OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
                case (opcode)
                  OP_BNE:  func_code = FUNC_BNE;
                  OP_BEQ:  func_code = FUNC_BEQ;
                  OP_BGZ:  func_code = FUNC_BGZ;
                  default: func_code = FUNC_BLZ;
                endcase
                alu_src_a     = 1'b1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
              end
              OP_JMP, OP_JAL: begin
                func_code = FUNC_JMP;
                alu_src_b = 2'd3;
                pc_write  = 1'b1;
                pc_source = 2'd2;
                if (opcode == OP_JAL) begin
                  reg_write  = 1'b1;
                  reg_dst    = 2'd2;
                  mem_to_reg = 2'd2;
                end
              end
              OP_RTYPE: begin
                if (isJpr || isJrl) begin
                  pc_write  = 1'b1;
                  pc_source = 2'd3;
                end
                if (isJrl) begin
                  reg_write  = 1'b1;
                  reg_dst    = 2'd2;
                  mem_to_reg = 2'd2;
                end
                if (isWwd) begin
                  wwd       = 1'b1;
                  alu_src_a = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        ST_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = (opcode == OP_LWD);
          mem_write = (opcode == OP_SWD);
        end
        ST_WB: begin
          reg_write  = 1'b1;
          reg_dst    = isRType ? 2'd1 : 2'd0;
          mem_to_reg = (opcode == OP_LWD) ? 2'd1 : 2'd0;
        end
        ST_HALT: is_halted = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CTRL_INST_COUNT_EN
  logic                 retire;
  logic [CNT_WIDTH-1:0] instCount;

  // An instruction retires when it leaves EX/MEM/WB for IF, or when HLT
  // reaches the halt state; illegal opcodes leave from ID and are not counted.
  always_comb begin
    retire = ((state == ST_EX || state == ST_MEM || state == ST_WB) && nextState == ST_IF)
          || (state == ST_ID && nextState == ST_HALT);
  end

  // Retired-instruction counter, wrapping naturally at its width.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    instCount <= '0;
    else if (retire) instCount <= instCount + 1'b1;
  end

  assign num_inst = instCount;
`else
  assign num_inst = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for the multi-cycle sequencer. Each cycle drives inst and
//   the handshake at the falling edge, then compares the full control word
//   against a hand-built expected value. Instantiated with a 4-bit counter so
//   the wrap of num_inst is reachable quickly.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int CW = 4;

  typedef struct packed {
    logic [3:0] funcCode;
    logic       srcA;
    logic [1:0] srcB;
    logic [1:0] pcSource;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic       wwd;
    logic       halted;
  } ctl_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [15:0]   inst = 16'h0000;
  logic          mem_ready = 1'b0;
  logic          alu_b_result = 1'b0;
  logic [3:0]    func_code;
  logic          alu_src_a;
  logic [1:0]    alu_src_b;
  logic [1:0]    pc_source;
  logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic          ir_write, reg_write, wwd, is_halted;
  logic [1:0]    reg_dst, mem_to_reg;
  logic [CW-1:0] num_inst;
  ctl_t          obs;

  int errors = 0;
  int checks = 0;
  int expCount = 0;

  multicycle_ctrl #(.WORD_SIZE(16), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .inst(inst), .mem_ready(mem_ready),
    .alu_b_result(alu_b_result), .func_code(func_code), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .wwd(wwd),
    .is_halted(is_halted), .num_inst(num_inst)
  );

  always #5 clk = ~clk;

  assign obs = {func_code, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
                i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                wwd, is_halted};

  function automatic logic [31:0] expNum();
`ifdef CTRL_INST_COUNT_EN
    return 32'(expCount % 16);
`else
    return 32'd0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] instIn, input logic ready,
                               input logic bRes);
    @(negedge clk);
    inst = instIn;
    mem_ready = ready;
    alu_b_result = bRes;
    #1;
  endtask

  task automatic stepCheck(input string tag, input logic ready, input ctl_t e);
    applyStimulus(inst, ready, alu_b_result);
    checkOutput(tag, 32'(obs), 32'(e));
  endtask

  task automatic fetch(input string tag, input logic [15:0] instIn);
    ctl_t e;
    applyStimulus(instIn, 1'b1, 1'b0);
    e = '0;
    e.memRead = 1'b1; e.srcB = 2'd1; e.irWrite = 1'b1; e.pcWrite = 1'b1;
    checkOutput({tag, "-IF"}, 32'(obs), 32'(e));
    checkOutput({tag, "-count"}, 32'(num_inst), expNum());
  endtask

  task automatic decodeStep(input string tag);
    ctl_t e;
    e = '0;
    e.srcB = 2'd2;
    stepCheck({tag, "-ID"}, 1'b1, e);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ctl_t e;

    // Reset: every output idle even though the state would otherwise fetch.
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset-ctl", 32'(obs), 32'd0);
    checkOutput("reset-count", 32'(num_inst), 32'd0);
    mem_ready = 1'b0;
    reset_n = 1'b1;

    // R-type ADD r1 = r2 + r3.
    fetch("ADD", 16'hFB40);
    decodeStep("ADD");
    e = '0; e.srcA = 1'b1;
    stepCheck("ADD-EX", 1'b1, e);
    e = '0; e.regWrite = 1'b1; e.regDst = 2'd1;
    stepCheck("ADD-WB", 1'b1, e);
    expCount++;

    // R-type SUB: function field mapped onto the ALU code.
    fetch("SUB", 16'hFB41);
    decodeStep("SUB");
    e = '0; e.srcA = 1'b1; e.funcCode = 4'd1;
    stepCheck("SUB-EX", 1'b1, e);
    e = '0; e.regWrite = 1'b1; e.regDst = 2'd1;
    stepCheck("SUB-WB", 1'b1, e);
    expCount++;

    // LWD with one fetch wait and three MEM wait cycles.
    applyStimulus(16'h7405, 1'b0, 1'b0);
    e = '0; e.memRead = 1'b1; e.srcB = 2'd1;
    checkOutput("LWD-IFwait", 32'(obs), 32'(e));
    fetch("LWD", 16'h7405);
    decodeStep("LWD");
    e = '0; e.srcA = 1'b1; e.srcB = 2'd2;
    stepCheck("LWD-EX", 1'b1, e);
    e = '0; e.iOrD = 1'b1; e.memRead = 1'b1;
    for (int i = 0; i < 3; i++) stepCheck("LWD-MEMwait", 1'b0, e);
    stepCheck("LWD-MEMdone", 1'b1, e);
    e = '0; e.regWrite = 1'b1; e.memToReg = 2'd1;
    stepCheck("LWD-WB", 1'b1, e);
    expCount++;

    // BEQ taken and not taken: identical control, three cycles each.
    for (int i = 0; i < 2; i++) begin
      fetch("BEQ", 16'h1605);
      decodeStep("BEQ");
      applyStimulus(16'h1605, 1'b1, (i == 0));
      e = '0; e.funcCode = 4'd11; e.srcA = 1'b1; e.pcWriteCond = 1'b1; e.pcSource = 2'd1;
      checkOutput("BEQ-EX", 32'(obs), 32'(e));
      expCount++;
    end

    // ADI then LHI: immediate forms write back to rt.
    fetch("ADI", 16'h4403);
    decodeStep("ADI");
    e = '0; e.srcA = 1'b1; e.srcB = 2'd2;
    stepCheck("ADI-EX", 1'b1, e);
    e = '0; e.regWrite = 1'b1;
    stepCheck("ADI-WB", 1'b1, e);
    expCount++;
    fetch("LHI", 16'h6012);
    decodeStep("LHI");
    e = '0; e.funcCode = 4'd8; e.srcA = 1'b1; e.srcB = 2'd3;
    stepCheck("LHI-EX", 1'b1, e);
    e = '0; e.regWrite = 1'b1;
    stepCheck("LHI-WB", 1'b1, e);
    expCount++;

    // JAL: jump plus link write to $2, next state IF.
    fetch("JAL", 16'hA123);
    decodeStep("JAL");
    e = '0; e.funcCode = 4'd9; e.srcB = 2'd3; e.pcWrite = 1'b1; e.pcSource = 2'd2;
    e.regWrite = 1'b1; e.regDst = 2'd2; e.memToReg = 2'd2;
    stepCheck("JAL-EX", 1'b1, e);
    expCount++;

    // JRL: register jump plus link.
    fetch("JRL", 16'hF01A);
    decodeStep("JRL");
    e = '0; e.pcWrite = 1'b1; e.pcSource = 2'd3;
    e.regWrite = 1'b1; e.regDst = 2'd2; e.memToReg = 2'd2;
    stepCheck("JRL-EX", 1'b1, e);
    expCount++;

    // Illegal opcode: back to IF after ID, not retired.
    fetch("ILL", 16'hB000);
    decodeStep("ILL");

    // SWD aborted by asynchronous reset in the middle of a MEM wait.
    fetch("SWD", 16'h8405);
    decodeStep("SWD");
    e = '0; e.srcA = 1'b1; e.srcB = 2'd2;
    stepCheck("SWD-EX", 1'b1, e);
    e = '0; e.iOrD = 1'b1; e.memWrite = 1'b1;
    stepCheck("SWD-MEMwait", 1'b0, e);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("SWD-abort-memwrite", 32'(mem_write), 32'd0);
    checkOutput("SWD-abort-ctl", 32'(obs), 32'd0);
    expCount = 0;
    @(negedge clk);
    checkOutput("SWD-abort-count", 32'(num_inst), expNum());
    mem_ready = 1'b0;
    reset_n = 1'b1;

    // Sixteen WWDs wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) begin
      fetch("WWD", 16'hF41C);
      decodeStep("WWD");
      e = '0; e.wwd = 1'b1; e.srcA = 1'b1;
      stepCheck("WWD-EX", 1'b1, e);
      expCount++;
    end

    // HLT: absorbing halt state, frozen for 20 cycles regardless of inputs.
    fetch("HLT", 16'hF01D);
    decodeStep("HLT");
    expCount++;
    e = '0; e.halted = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'hF01D, 1'(i % 2), 1'(i % 3 == 0));
      checkOutput("HALT-ctl", 32'(obs), 32'(e));
    end
    checkOutput("HALT-count", 32'(num_inst), expNum());

    // Reset pulse leaves the halt state.
    reset_n = 1'b0;
    #2;
    checkOutput("HALT-reset-halted", 32'(is_halted), 32'd0);
    checkOutput("HALT-reset-count", 32'(num_inst), 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    expCount = 0;
    fetch("POST", 16'hFB40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
